// File: rtl/display_scan.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// The shadow value/enable change only at frame boundaries, so every frame is tear-free.
module display_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK       = 4,
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int CW = $clog2(REFRESH_DIV)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  load,
  output logic [3:0]            display_data,
  output logic [DIGITS-1:0]     anode,
  output logic [IW-1:0]         digit_idx,
  output logic                  frame_done
);

  typedef struct packed {
    logic [DIGITS-1:0][3:0] val;
    logic [DIGITS-1:0]      en;
  } disp_t;

  logic [CW-1:0] cnt;
  logic [IW-1:0] dig;
  disp_t         shd, pnd;
  logic          pv;
  logic          slot_end, frame_end, lit;
  disp_t         req;

  assign slot_end  = (cnt == CW'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (dig == IW'(DIGITS - 1));
  assign req       = '{val: data, en: digit_en};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      dig        <= '0;
      shd        <= '0;
      pnd        <= '0;
      pv         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (slot_end) begin
        cnt <= '0;
        dig <= frame_end ? '0 : dig + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      // A load on the boundary edge bypasses the pending copy entirely.
      if (frame_end) begin
        if (load) begin
          shd <= req;
          pv  <= 1'b0;
        end else if (pv) begin
          shd <= pnd;
          pv  <= 1'b0;
        end
      end else if (load) begin
        pnd <= req;
        pv  <= 1'b1;
      end
    end
  end

  assign lit          = (cnt >= CW'(BLANK));
  assign display_data = shd.val[dig];
  assign digit_idx    = dig;

  for (genvar i = 0; i < DIGITS; i++) begin : g_anode
    assign anode[i] = !(lit && (dig == IW'(i)) && shd.en[i]);
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with DIGITS=4, REFRESH_DIV=8, BLANK=2 (32-cycle frame).
module tb_display_scan;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  digit_en;
  logic        load;
  logic [3:0]  display_data;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  display_scan #(.DIGITS(4), .REFRESH_DIV(8), .BLANK(2)) dut (
    .clk(clk), .rst(rst), .data(data), .digit_en(digit_en), .load(load),
    .display_data(display_data), .anode(anode), .digit_idx(digit_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]     d;
    logic [3:0]      en;
    logic [3:0][3:0] nib;   // expected display_data per slot
    logic [3:0][3:0] an;    // expected anode per slot once past the blank gap
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Cycle counter counts rising edges since reset release; sample #1 after each edge.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic load_at(input int e, input logic [15:0] d, input logic [3:0] en);
    while ((cyc % 32) != ((e + 31) % 32)) tick();
    data = d; digit_en = en; load = 1'b1;
    tick();
    load = 1'b0; data = 16'h0; digit_en = 4'h0;
  endtask

  task automatic wait_frame();
    do tick(); while ((cyc % 32) != 0);
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_anode"}, 32'(anode), 32'hf);
    chk({tag, "_data"},  32'(display_data), 32'h0);
    chk({tag, "_idx"},   32'(digit_idx), 32'((cyc / 8) % 4));
    chk({tag, "_fd"},    32'(frame_done), 32'((cyc % 32 == 0) && cyc > 0));
  endtask

  // Must be entered right after a boundary edge; leaves at the next one.
  task automatic scan_check(input string tag, input logic [3:0][3:0] nib,
                            input logic [3:0][3:0] an, input int ld_t,
                            input logic [15:0] ld_d, input logic [3:0] ld_en);
    for (int t = 0; t < 32; t++) begin
      chk({tag, "_data"},  32'(display_data), 32'(nib[t/8]));
      chk({tag, "_anode"}, 32'(anode), (t % 8 >= 2) ? 32'(an[t/8]) : 32'hf);
      chk({tag, "_idx"},   32'(digit_idx), 32'(t / 8));
      chk({tag, "_fd"},    32'(frame_done), 32'(t == 0));
      if (t == ld_t) begin
        data = ld_d; digit_en = ld_en; load = 1'b1;
      end
      tick();
      load = 1'b0;
    end
  endtask

  localparam logic [3:0][3:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  initial begin
    tbl[0] = '{d: 16'h1A3F, en: 4'b1111, nib: {4'h1, 4'hA, 4'h3, 4'hF}, an: AN_ALL};
    tbl[1] = '{d: 16'h8888, en: 4'b0101, nib: {4'h8, 4'h8, 4'h8, 4'h8},
               an: {4'b1111, 4'b1011, 4'b1111, 4'b1110}};
    tbl[2] = '{d: 16'h7E29, en: 4'b1010, nib: {4'h7, 4'hE, 4'h2, 4'h9},
               an: {4'b0111, 4'b1111, 4'b1101, 4'b1111}};
    tbl[3] = '{d: 16'h0000, en: 4'b1111, nib: {4'h0, 4'h0, 4'h0, 4'h0}, an: AN_ALL};

    rst = 1'b1; load = 1'b0; data = 16'hFFFF; digit_en = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_anode", 32'(anode), 32'hf);
    chk("rst_data",  32'(display_data), 32'h0);
    chk("rst_idx",   32'(digit_idx), 32'h0);
    chk("rst_fd",    32'(frame_done), 32'h0);
    @(negedge clk); rst = 1'b0; cyc = 0;

    // Dark for two frames; digit_en wiggling without load must not light anything.
    for (int i = 0; i < 64; i++) begin
      digit_en = 4'(i);
      tick();
      check_dark("idle");
    end
    data = 16'h0; digit_en = 4'h0;

    foreach (tbl[v]) begin
      load_at(5, tbl[v].d, tbl[v].en);
      wait_frame();
      scan_check($sformatf("tbl%0d", v), tbl[v].nib, tbl[v].an, -1, 16'h0, 4'h0);
    end

    // Tear-free: ABCD loaded during digit 2 of the 1234 frame shows only in the next frame.
    load_at(5, 16'h1234, 4'hF);
    wait_frame();
    scan_check("tear_old", {4'h1, 4'h2, 4'h3, 4'h4}, AN_ALL, 18, 16'hABCD, 4'hF);
    scan_check("tear_new", {4'hA, 4'hB, 4'hC, 4'hD}, AN_ALL, -1, 16'h0, 4'h0);

    // Last load wins.
    load_at(5, 16'h1111, 4'hF);
    load_at(10, 16'h2222, 4'hF);
    wait_frame();
    scan_check("last", {4'h2, 4'h2, 4'h2, 4'h2}, AN_ALL, -1, 16'h0, 4'h0);

    // Boundary-edge load beats pending 3333, and leaves nothing pending.
    load_at(10, 16'h3333, 4'hF);
    load_at(0, 16'h4444, 4'hF);
    scan_check("bnd1", {4'h4, 4'h4, 4'h4, 4'h4}, AN_ALL, -1, 16'h0, 4'h0);
    scan_check("bnd2", {4'h4, 4'h4, 4'h4, 4'h4}, AN_ALL, -1, 16'h0, 4'h0);

    // Mid-frame reset during digit 2, with a pending load that must be discarded.
    load_at(5, 16'h5678, 4'hF);
    wait_frame();
    load_at(12, 16'h9999, 4'hF);
    repeat (6) tick();
    chk("pre_rst_anode", 32'(anode), 32'b1011);
    chk("pre_rst_data",  32'(display_data), 32'h6);
    @(negedge clk); rst = 1'b1; #1;
    chk("mrst_anode", 32'(anode), 32'hf);
    chk("mrst_data",  32'(display_data), 32'h0);
    chk("mrst_idx",   32'(digit_idx), 32'h0);
    chk("mrst_fd",    32'(frame_done), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; cyc = 0;
    chk("rel_idx", 32'(digit_idx), 32'h0);
    for (int i = 0; i < 40; i++) begin
      tick();
      check_dark("post_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
